// File: rtl/dsp48a1_mac_ctrl.sv
// Sequencer that drives a DSP48A1 slice as a vector multiply-accumulate engine.
// Operand pairs stream in on valid/ready; the final P and a sticky carry are returned on a result port.
module dsp48a1_mac_ctrl #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_cfg_len,
    input  logic             i_cfg_sub,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [17:0]      i_in_a,
    input  logic [17:0]      i_in_b,
    output logic [17:0]      o_dsp_a,
    output logic [17:0]      o_dsp_b,
    output logic             o_dsp_cea,
    output logic             o_dsp_ceb,
    output logic [7:0]       o_dsp_opmode,
    output logic             o_dsp_ceopmode,
    output logic             o_dsp_cem,
    output logic             o_dsp_cep,
    output logic             o_dsp_rst,
    input  logic [47:0]      i_dsp_p,
    input  logic             i_dsp_carryout,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [47:0]      o_res_data,
    output logic             o_res_carry,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic             r_v1;
    logic             r_v2;
    logic             r_v3;
    logic [LEN_W-1:0] r_rem;
    logic             r_first;
    logic             r_sub;
    logic [7:0]       r_opmode;
    logic [47:0]      r_res_data;
    logic             r_res_carry;
    logic             r_res_valid;
    logic             r_in_ready;
    logic             r_busy;
    logic             r_dsp_rst;
    logic             w_accept;

    assign w_accept       = i_in_valid & r_in_ready;
    assign o_in_ready     = r_in_ready;
    assign o_dsp_a        = i_in_a;
    assign o_dsp_b        = i_in_b;
    assign o_dsp_cea      = w_accept;
    assign o_dsp_ceb      = w_accept;
    assign o_dsp_opmode   = r_opmode;
    assign o_dsp_ceopmode = r_v1;
    assign o_dsp_cem      = r_v1;
    assign o_dsp_cep      = r_v2;
    assign o_dsp_rst      = r_dsp_rst;
    assign o_res_valid    = r_res_valid;
    assign o_res_data     = r_res_data;
    assign o_res_carry    = r_res_carry;
    assign o_busy         = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_v3        <= 1'b0;
            r_rem       <= '0;
            r_first     <= 1'b0;
            r_sub       <= 1'b0;
            r_opmode    <= 8'h00;
            r_res_data  <= 48'h0;
            r_res_carry <= 1'b0;
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_dsp_rst   <= 1'b1;
        end else begin
            r_dsp_rst <= 1'b0;
            r_v1      <= w_accept;
            r_v2      <= r_v1;
            r_v3      <= r_v2;

            // First beat uses Z=0 so a stale P from an earlier vector is dropped.
            if (w_accept) begin
                r_opmode <= {r_sub, 3'b000, ~r_first, 3'b001};
            end

            // The slice carry register loads together with P, so it is valid alongside v3.
            if (r_v3) begin
                r_res_carry <= r_res_carry | i_dsp_carryout;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start && (i_cfg_len != '0)) begin
                        r_state     <= S_ACCUM;
                        r_rem       <= i_cfg_len;
                        r_sub       <= i_cfg_sub;
                        r_first     <= 1'b1;
                        r_res_carry <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        r_rem   <= r_rem - LEN_W'(1);
                        r_first <= 1'b0;
                        if (r_rem == LEN_W'(1)) begin
                            r_state    <= S_DRAIN;
                            r_in_ready <= 1'b0;
                        end
                    end
                end
                S_DRAIN: begin
                    // No accepts happen in DRAIN, so an empty pipe behind v3 marks the last beat.
                    if (r_v3 && !r_v2 && !r_v1) begin
                        r_res_data  <= i_dsp_p;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp48a1_mac_ctrl.sv
// Bench for dsp48a1_mac_ctrl with a behavioural DSP48A1 slice model.
// Expected results are queued at command time and popped by a monitor on each result handshake.
module tb_dsp48a1_mac_ctrl;

    typedef struct {
        logic [47:0] data;
        logic        carry;
    } result_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [15:0] cfgLen;
    logic        cfgSub;
    logic        inValid;
    logic        inReady;
    logic [17:0] inA;
    logic [17:0] inB;
    logic [17:0] dspA;
    logic [17:0] dspB;
    logic        dspCea;
    logic        dspCeb;
    logic [7:0]  dspOpmode;
    logic        dspCeopmode;
    logic        dspCem;
    logic        dspCep;
    logic        dspRst;
    logic [47:0] dspP;
    logic        dspCarryout;
    logic        resValid;
    logic        resReady;
    logic [47:0] resData;
    logic        resCarry;
    logic        busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lastAcc = 0;
    bit latChk = 1'b0;
    bit prevValid = 1'b0;
    int cemCount = 0;
    int cepCount = 0;
    result_t expQ[$];

    dsp48a1_mac_ctrl #(.LEN_W(16)) dut (
        .clk(clk), .rst_n(rstN), .i_start(start), .i_cfg_len(cfgLen), .i_cfg_sub(cfgSub),
        .i_in_valid(inValid), .o_in_ready(inReady), .i_in_a(inA), .i_in_b(inB),
        .o_dsp_a(dspA), .o_dsp_b(dspB), .o_dsp_cea(dspCea), .o_dsp_ceb(dspCeb),
        .o_dsp_opmode(dspOpmode), .o_dsp_ceopmode(dspCeopmode), .o_dsp_cem(dspCem),
        .o_dsp_cep(dspCep), .o_dsp_rst(dspRst), .i_dsp_p(dspP), .i_dsp_carryout(dspCarryout),
        .o_res_valid(resValid), .i_res_ready(resReady), .o_res_data(resData),
        .o_res_carry(resCarry), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slice model: A1/B1, M, OPMODE and P/CARRYOUT registers, all cleared by the sync reset.
    logic [17:0] mA1;
    logic [17:0] mB1;
    logic [35:0] mM;
    logic [7:0]  mOp;
    logic [47:0] mP;
    logic        mCo;

    function automatic logic [48:0] postAdd(input logic [7:0] op, input logic [35:0] m, input logic [47:0] p);
        logic [47:0] z;
        z = op[3] ? p : 48'h0;
        return op[7] ? ({1'b0, z} - {13'b0, m}) : ({1'b0, z} + {13'b0, m});
    endfunction

    always @(posedge clk) begin
        if (dspRst) begin
            mA1 <= '0; mB1 <= '0; mM <= '0; mOp <= '0; mP <= '0; mCo <= 1'b0;
        end else begin
            if (dspCea) mA1 <= dspA;
            if (dspCeb) mB1 <= dspB;
            if (dspCem) mM <= 36'(mA1) * 36'(mB1);
            if (dspCeopmode) mOp <= dspOpmode;
            if (dspCep) begin
                mP  <= postAdd(mOp, mM, mP)[47:0];
                mCo <= postAdd(mOp, mM, mP)[48];
            end
        end
    end

    assign dspP        = mP;
    assign dspCarryout = mCo;

    task automatic checkOutput(input string name, input logic [47:0] actual, input logic [47:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout want event (cycle %0d)", name, cyc);
    endtask

    // Monitor: pops the scoreboard on every result handshake and tracks result latency.
    always @(negedge clk) begin
        if (rstN) begin
            if (dspCem) cemCount++;
            if (dspCep) cepCount++;
            if (resValid && !prevValid && latChk) begin
                checkOutput("latency", 48'(cyc - lastAcc), 48'd3);
                latChk = 1'b0;
            end
            if (resValid && resReady) begin
                if (expQ.size() == 0) begin
                    failNow("unexpected_result");
                end else begin
                    result_t e;
                    e = expQ.pop_front();
                    checkOutput("res_data", resData, e.data);
                    checkOutput("res_carry", 48'(resCarry), 48'(e.carry));
                end
            end
        end
        prevValid = resValid;
    end

    task automatic startVector(input int len, input bit sub, input bit push,
                               input logic [47:0] expData, input bit expCarry);
        result_t e;
        start  = 1'b1;
        cfgLen = 16'(len);
        cfgSub = sub;
        @(posedge clk); #1;
        start = 1'b0;
        if (push) begin
            e.data  = expData;
            e.carry = expCarry;
            expQ.push_back(e);
        end
    endtask

    task automatic sendPair(input logic [17:0] a, input logic [17:0] b, input int gap);
        bit acc;
        int budget;
        inValid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        inA = a;
        inB = b;
        inValid = 1'b1;
        acc = 1'b0;
        budget = 0;
        while (!acc && budget < 100) begin
            @(negedge clk);
            acc = inReady;
            @(posedge clk); #1;
            budget++;
        end
        inValid = 1'b0;
        lastAcc = cyc;
        if (!acc) failNow("accept_timeout");
    endtask

    task automatic waitIdle();
        int budget;
        budget = 0;
        @(negedge clk);
        while (busy && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (busy) failNow("idle_timeout");
        @(posedge clk); #1;
    endtask

    task automatic applyStimulus(input int len, input bit sub, input logic [17:0] a[$],
                                 input logic [17:0] b[$], input int gap,
                                 input logic [47:0] expData, input bit expCarry);
        startVector(len, sub, 1'b1, expData, expCarry);
        for (int i = 0; i < a.size(); i++) sendPair(a[i], b[i], (i == 0) ? 0 : gap);
        waitIdle();
    endtask

    initial begin
        logic [17:0] qa[$];
        logic [17:0] qb[$];
        rstN = 1'b0; start = 1'b0; cfgLen = '0; cfgSub = 1'b0;
        inValid = 1'b0; inA = '0; inB = '0; resReady = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_dsp_rst", 48'(dspRst), 48'd1);
        checkOutput("reset_busy", 48'(busy), 48'd0);
        checkOutput("reset_res_valid", 48'(resValid), 48'd0);
        checkOutput("reset_opmode", 48'(dspOpmode), 48'd0);
        checkOutput("reset_res_data", resData, 48'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("rst_release_hold", 48'(dspRst), 48'd1);
        @(negedge clk);
        checkOutput("rst_release_drop", 48'(dspRst), 48'd0);
        @(posedge clk); #1;

        $display("[TB] vector LEN=3 no bubbles");
        qa = '{18'd2, 18'd4, 18'd6};
        qb = '{18'd3, 18'd5, 18'd7};
        latChk = 1'b1;
        applyStimulus(3, 1'b0, qa, qb, 0, 48'd68, 1'b0);
        checkOutput("latency_seen", 48'(latChk), 48'd0);

        $display("[TB] vector LEN=3 with bubbles");
        cemCount = 0;
        cepCount = 0;
        applyStimulus(3, 1'b0, qa, qb, 2, 48'd68, 1'b0);
        checkOutput("cem_pulses", 48'(cemCount), 48'd3);
        checkOutput("cep_pulses", 48'(cepCount), 48'd3);

        $display("[TB] subtract LEN=1");
        qa = '{18'd10};
        qb = '{18'd10};
        applyStimulus(1, 1'b1, qa, qb, 0, 48'hFFFF_FFFF_FF9C, 1'b1);

        $display("[TB] long vector overflowing P");
        startVector(4100, 1'b0, 1'b1, 48'h003F_7FE0_1004, 1'b1);
        for (int i = 0; i < 4100; i++) sendPair(18'h3FFFF, 18'h3FFFF, 0);
        waitIdle();
        qa = '{18'd2, 18'd4, 18'd6};
        qb = '{18'd3, 18'd5, 18'd7};
        applyStimulus(3, 1'b0, qa, qb, 0, 48'd68, 1'b0);

        $display("[TB] zero length and held result");
        startVector(0, 1'b0, 1'b0, 48'd0, 1'b0);
        @(negedge clk);
        checkOutput("len0_busy", 48'(busy), 48'd0);
        checkOutput("len0_ready", 48'(inReady), 48'd0);
        @(posedge clk); #1;
        resReady = 1'b0;
        startVector(1, 1'b0, 1'b1, 48'd12, 1'b0);
        sendPair(18'd3, 18'd4, 0);
        begin
            int budget;
            budget = 0;
            @(negedge clk);
            while (!resValid && budget < 20) begin @(negedge clk); budget++; end
            if (!resValid) failNow("done_timeout");
        end
        @(posedge clk); #1;
        start = 1'b1;
        cfgLen = 16'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("hold_data", resData, 48'd12);
            checkOutput("hold_valid", 48'(resValid), 48'd1);
            @(posedge clk); #1;
            start = 1'b0;
        end
        checkOutput("hold_ready", 48'(inReady), 48'd0);
        resReady = 1'b1;
        waitIdle();
        @(negedge clk);
        checkOutput("after_done_busy", 48'(busy), 48'd0);
        @(posedge clk); #1;

        $display("[TB] reset mid vector");
        startVector(5, 1'b0, 1'b0, 48'd0, 1'b0);
        sendPair(18'd7, 18'd9, 0);
        sendPair(18'd7, 18'd9, 0);
        rstN = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", 48'(busy), 48'd0);
        checkOutput("midrst_ready", 48'(inReady), 48'd0);
        checkOutput("midrst_dsp_rst", 48'(dspRst), 48'd1);
        @(posedge clk); #1;
        rstN = 1'b1;
        @(negedge clk);
        checkOutput("midrst_release", 48'(dspRst), 48'd1);
        @(negedge clk);
        checkOutput("midrst_drop", 48'(dspRst), 48'd0);
        @(posedge clk); #1;
        qa = '{18'd1, 18'd1};
        qb = '{18'd1, 18'd1};
        applyStimulus(2, 1'b0, qa, qb, 0, 48'd2, 1'b0);

        repeat (3) @(posedge clk);
        if (expQ.size() != 0) failNow("results_missing");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
